key_pulse_conditioner: RTL and testbench

- Upstream front end for the scene state machine. Converts the five raw board push-buttons (C, U, D, L, R) into clean single-cycle key pulses.
- Per button: 2-flop synchronizer, debounce filter and rising-edge one-shot.
- Directional keys also get an optional hold-to-repeat, for cursor movement in the choose and fight scenes.
- key_C never repeats, so a held centre button cannot skip scenes.

---
 rtl/key_pulse_conditioner.sv | 183 ++++++++++++++++++
 tb/tb_key_pulse_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/key_pulse_conditioner.sv
// Push-button front end: sync, debounce, press one-shot and
// optional hold-to-repeat for the five board buttons.
//
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high
//   btn_raw  - raw async buttons {R,L,D,U,C}
//   key_C    - centre press pulse (never repeats)
//   key_U/D/L/R - directional press/repeat pulses
//   key_held - debounced button levels {R,L,D,U,C}
module key_pulse_conditioner #(
  parameter int unsigned DEB_CYCLES   = 100000,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000,
  parameter logic [4:0]  REPEAT_EN    = 5'b11110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_raw,
  output logic       key_C,
  output logic       key_U,
  output logic       key_D,
  output logic       key_L,
  output logic       key_R,
  output logic [4:0] key_held
);

  localparam int unsigned DW =
    $clog2(DEB_CYCLES + 1);
  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_RATE) ?
    REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW =
    $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST =
    RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST =
    RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RATE  = 2'd2
  } rep_state_t;

  logic [4:0]    s1;
  logic [4:0]    s2;
  logic [4:0]    held;
  logic [DW-1:0] cnt [5];
  logic [4:0]    rise;
  logic [4:0]    rep;
  logic [4:0]    key_q;

  // Synchronizer and per-bit debounce. Any sample that
  // agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      held <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == held[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          held[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  // High exactly on the edge where held goes 0->1.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 5; i++) begin
      rise[i] = ~held[i] & s2[i] &
                (cnt[i] == DEB_LAST);
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_key
    if (REPEAT_EN[g]) begin : g_rep
      rep_state_t    st;
      rep_state_t    st_n;
      logic [RW-1:0] rcnt;
      logic [RW-1:0] rcnt_n;
      logic          fire;

      always_ff @(posedge clk) begin
        if (reset) begin
          st   <= IDLE;
          rcnt <= '0;
        end else begin
          st   <= st_n;
          rcnt <= rcnt_n;
        end
      end

      always_comb begin
        st_n   = st;
        rcnt_n = rcnt;
        unique case (st)
          IDLE: begin
            if (rise[g]) begin
              st_n   = DELAY;
              rcnt_n = '0;
            end
          end
          DELAY: begin
            if (!held[g]) begin
              st_n   = IDLE;
              rcnt_n = '0;
            end else if (rcnt == DLY_LAST) begin
              st_n   = RATE;
              rcnt_n = '0;
            end else begin
              rcnt_n = rcnt + RW'(1);
            end
          end
          RATE: begin
            if (!held[g]) begin
              st_n   = IDLE;
              rcnt_n = '0;
            end else if (rcnt == RATE_LAST) begin
              rcnt_n = '0;
            end else begin
              rcnt_n = rcnt + RW'(1);
            end
          end
          default: begin
            st_n   = IDLE;
            rcnt_n = '0;
          end
        endcase
      end

      // A release in the firing cycle cancels the pulse.
      always_comb begin
        fire = 1'b0;
        unique case (1'b1)
          (st == DELAY): fire = held[g] &
                                (rcnt == DLY_LAST);
          (st == RATE):  fire = held[g] &
                                (rcnt == RATE_LAST);
          default:       fire = 1'b0;
        endcase
      end

      assign rep[g] = fire;
    end else begin : g_norep
      assign rep[g] = 1'b0;
    end
  end

  // Press and repeat are mutually exclusive per key:
  // rise needs held=0, fire needs held=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
    end else begin
      key_q <= rise | rep;
    end
  end

  assign key_C    = key_q[0];
  assign key_U    = key_q[1];
  assign key_D    = key_q[2];
  assign key_L    = key_q[3];
  assign key_R    = key_q[4];
  assign key_held = held;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Bench for key_pulse_conditioner: expected pulses are
// queued at stimulus time and matched as the DUT fires.
module tb_key_pulse_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic       key_C;
  logic       key_U;
  logic       key_D;
  logic       key_L;
  logic       key_R;
  logic [4:0] key_held;
  logic [4:0] keys;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int base;

  typedef struct {
    int         at;
    logic [4:0] mask;
  } exp_t;

  exp_t sb[$];

  key_pulse_conditioner #(
    .DEB_CYCLES  (4),
    .REPEAT_DELAY(8),
    .REPEAT_RATE (3),
    .REPEAT_EN   (5'b11110)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .key_C   (key_C),
    .key_U   (key_U),
    .key_D   (key_D),
    .key_L   (key_L),
    .key_R   (key_R),
    .key_held(key_held)
  );

  assign keys = {key_R, key_L, key_D, key_U, key_C};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at,
                              input logic [4:0] mask);
    exp_t e;
    e.at   = at;
    e.mask = mask;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every observed pulse must match
  // the oldest queued expectation in cycle and key mask.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (keys != 5'b0) begin
        if (sb.size() == 0) begin
          chk("spurious_pulse", 32'(keys), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pulse_cycle", cyc, e.at);
          chk("pulse_keys", 32'(keys), 32'(e.mask));
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    btn_raw = 5'b11111;

    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_keys", 32'(keys), 32'd0);
      chk("rst_held", 32'(key_held), 32'd0);
    end
    reset   = 1'b0;
    btn_raw = 5'b00000;
    step(1);
    chk("post_rst_keys", 32'(keys), 32'd0);
    chk("post_rst_held", 32'(key_held), 32'd0);
    step(3);

    // Centre press: single pulse, no repeat.
    btn_raw[0] = 1'b1;
    base = cyc;
    expect_pulse(base + 6, 5'b00001);
    step(5);
    chk("c_held_early", 32'(key_held[0]), 32'd0);
    step(1);
    chk("c_held_rise", 32'(key_held[0]), 32'd1);
    step(14);
    btn_raw[0] = 1'b0;
    step(5);
    chk("c_held_tail", 32'(key_held[0]), 32'd1);
    step(1);
    chk("c_held_fall", 32'(key_held[0]), 32'd0);
    step(4);

    // Bounce shorter than the debounce window.
    btn_raw[0] = 1'b1;
    step(3);
    btn_raw[0] = 1'b0;
    step(1);
    btn_raw[0] = 1'b1;
    step(3);
    btn_raw[0] = 1'b0;
    step(10);
    chk("bounce_held", 32'(key_held), 32'd0);

    // U and C held together for 30 cycles.
    btn_raw[1:0] = 2'b11;
    base = cyc;
    expect_pulse(base + 6, 5'b00011);
    expect_pulse(base + 14, 5'b00010);
    for (int k = 17; k <= 35; k += 3) begin
      expect_pulse(base + k, 5'b00010);
    end
    step(30);
    btn_raw[1:0] = 2'b00;
    step(5);
    chk("u_held_tail", 32'(key_held), 32'h3);
    step(1);
    chk("u_held_fall", 32'(key_held), 32'd0);
    step(5);

    // L and R together; released before first repeat.
    btn_raw[4:3] = 2'b11;
    base = cyc;
    expect_pulse(base + 6, 5'b11000);
    step(6);
    chk("lr_held", 32'(key_held), 32'h18);
    step(1);
    btn_raw[4:3] = 2'b00;
    step(12);
    chk("lr_released", 32'(key_held), 32'd0);

    // D held across a one-cycle reset.
    btn_raw[2] = 1'b1;
    base = cyc;
    expect_pulse(base + 6, 5'b00100);
    expect_pulse(base + 14, 5'b00100);
    expect_pulse(base + 22, 5'b00100);
    for (int k = 30; k <= 39; k += 3) begin
      expect_pulse(base + k, 5'b00100);
    end
    step(15);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("d_rst_held", 32'(key_held), 32'd0);
    chk("d_rst_keys", 32'(keys), 32'd0);
    step(5);
    chk("d_held_early", 32'(key_held[2]), 32'd0);
    step(1);
    chk("d_held_again", 32'(key_held[2]), 32'd1);
    step(12);
    btn_raw[2] = 1'b0;
    step(5);
    chk("d_held_tail", 32'(key_held[2]), 32'd1);
    step(1);
    chk("d_held_fall", 32'(key_held[2]), 32'd0);
    step(6);

    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
